// File: rtl/psi_gen_pkg.sv
// psi_gen_pkg
// Shared definitions for the PSI pulse generator:
//   psi_gen_state_t    - generator phase (IDLE, HIGH, LOW)
//   PSI_GEN_WIDTH      - default divisor width
//   PSI_GEN_HIGH_TICKS - default prescaler ticks per PSI high phase
//   PSI_GEN_LOW_TICKS  - default prescaler ticks per PSI low phase
package psi_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } psi_gen_state_t;

  localparam int PSI_GEN_WIDTH      = 8;
  localparam int PSI_GEN_HIGH_TICKS = 4;
  localparam int PSI_GEN_LOW_TICKS  = 4;

endpackage

// File: rtl/psi_tick_prescaler.sv
// psi_tick_prescaler
// Divides clk by div while run is high. The counter runs 0 .. div-1 and
// returns to 0 on the terminal count. tick is registered, so it is high
// in the cycle right after the terminal-count edge, together with any
// PSI edge the parent FSM takes on that same edge.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   run   - count enable; when low the counter is held at 0
//   div   - divisor (never 0; the parent clamps it)
//   count - current prescaler count
//   tick  - one-cycle pulse following every terminal count
module psi_tick_prescaler
  import psi_gen_pkg::*;
#(
  parameter int WIDTH = PSI_GEN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] count,
  output logic             tick
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             tick_reg;
  logic             tick_next;
  logic             terminal;

  // '>=' rather than '==' keeps the counter from running away should the
  // divisor ever shrink below the current count.
  assign terminal = run && (count_reg >= (div - WIDTH'(1)));

  always_comb begin
    count_next = '0;
    tick_next  = terminal;
    if (run && !terminal) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tick_reg  <= tick_next;
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;

endmodule

// File: rtl/psi_pulse_generator.sv
// psi_pulse_generator
// Drives the PSI waveform for the frequency-regulation loop. clk is divided
// by div = ~adjust_div (0 clamps to 1); PSI stays high for HIGH_TICKS and
// low for LOW_TICKS prescaler ticks. Dropping en lets the running period
// finish before the generator returns to IDLE.
// Build option:
//   PSI_GEN_LATCH_EN defined   - divisor latched only on entry to HIGH
//   PSI_GEN_LATCH_EN undefined - divisor reloaded on every prescaler tick
// Ports:
//   clk         - clock
//   rst         - asynchronous active-high reset
//   en          - run request (level)
//   adjust_div  - inverted divisor from the regulator
//   psi         - generated PSI waveform (registered)
//   tick        - one-cycle pulse on each prescaler terminal count
//   period_done - one-cycle pulse on the last tick of each LOW phase
module psi_pulse_generator
  import psi_gen_pkg::*;
#(
  parameter int WIDTH      = PSI_GEN_WIDTH,
  parameter int HIGH_TICKS = PSI_GEN_HIGH_TICKS,
  parameter int LOW_TICKS  = PSI_GEN_LOW_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] adjust_div,
  output logic             psi,
  output logic             tick,
  output logic             period_done
);

  localparam int MAX_TICKS = (HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS;
  localparam int PH_W      = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_TICKS - 1);
  localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_TICKS - 1);

  psi_gen_state_t   state_reg, state_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [WIDTH-1:0] div_q_reg, div_q_next;
  logic             psi_reg, psi_next;
  logic             period_done_reg, period_done_next;

  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] pre_count;
  logic             pre_tick;
  logic             run;
  logic             terminal;

  // Effective divisor; an all-ones adjust_div would give 0, which clamps to 1.
  always_comb begin
    div_eff = ~adjust_div;
    if (div_eff == '0) begin
      div_eff = WIDTH'(1);
    end
  end

  assign run = (state_reg != IDLE);

  psi_tick_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .div   (div_q_reg),
    .count (pre_count),
    .tick  (pre_tick)
  );

  // Same-edge view of the prescaler terminal count, so the phase counter and
  // PSI move on the edge that also raises the registered tick.
  assign terminal = run && (pre_count >= (div_q_reg - WIDTH'(1)));

  always_comb begin
    state_next       = state_reg;
    phase_next       = phase_reg;
    div_q_next       = div_q_reg;
    period_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        phase_next = '0;
        if (en) begin
          state_next = HIGH;
          div_q_next = div_eff;
        end
      end

      HIGH: begin
        if (terminal) begin
          phase_next = phase_reg + PH_W'(1);
`ifndef PSI_GEN_LATCH_EN
          div_q_next = div_eff;
`endif
          if (phase_reg == HIGH_LAST) begin
            state_next = LOW;
            phase_next = '0;
          end
        end
      end

      LOW: begin
        if (terminal) begin
          phase_next = phase_reg + PH_W'(1);
`ifndef PSI_GEN_LATCH_EN
          div_q_next = div_eff;
`endif
          if (phase_reg == LOW_LAST) begin
            period_done_next = 1'b1;
            phase_next       = '0;
            if (en) begin
              state_next = HIGH;
              div_q_next = div_eff;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase

    psi_next = (state_next == HIGH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      phase_reg       <= '0;
      div_q_reg       <= WIDTH'(1);
      psi_reg         <= 1'b0;
      period_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      div_q_reg       <= div_q_next;
      psi_reg         <= psi_next;
      period_done_reg <= period_done_next;
    end
  end

  assign psi         = psi_reg;
  assign tick        = pre_tick;
  assign period_done = period_done_reg;

endmodule
